// File: rtl/bamf_ctrl_pkg.sv
// Shared types and constants for the BAMF run/halt/step controller.
package bamf_ctrl_pkg;

  localparam int unsigned DP_W        = 16;
  localparam int unsigned DEF_CYCLE_W = 32;
  localparam logic [31:0] DEF_TIMEOUT = 32'd1_000_000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT,
    ST_STEP,
    ST_INJECT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/bamf_cycle_counter.sv
// Saturating up-counter with synchronous clear/enable and asynchronous reset.
module bamf_cycle_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/bamf_run_controller.sv
// Run/halt/step/inject sequencer gating the BAMF datapath clock enable.
module bamf_run_controller
  import bamf_ctrl_pkg::*;
#(
  parameter int unsigned CYCLE_W = DEF_CYCLE_W,
  parameter logic [31:0] TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               halt_req,
  input  logic               step,
  input  logic               inject_valid,
  output logic               inject_ready,
  input  logic [DP_W-1:0]    inject_instr,
  input  logic [DP_W-1:0]    inject_memb,
  input  logic               dp_outport_we,
  input  logic [DP_W-1:0]    dp_outport,
  output logic               dp_clk_en,
  output logic               dp_debug,
  output logic [DP_W-1:0]    dp_debug_instr,
  output logic [DP_W-1:0]    dp_debug_memb,
  output logic [DP_W-1:0]    result,
  output logic               done,
  output logic               timeout,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic               busy
);

  localparam logic [CYCLE_W:0] LIMIT = (CYCLE_W+1)'(TIMEOUT);

  state_t          state;
  logic [DP_W-1:0] inj_instr_q;
  logic [DP_W-1:0] inj_memb_q;
  logic [CYCLE_W:0] count_inc;
  logic            at_limit;
  logic            cnt_clr;

  // One bit wider so a saturated counter cannot wrap into a false limit hit.
  assign count_inc = {1'b0, cycle_count} + (CYCLE_W+1)'(1);
  assign at_limit  = (count_inc == LIMIT);
  assign cnt_clr   = start && ((state == ST_IDLE) || (state == ST_DONE));

  always_comb begin
    dp_clk_en      = state inside {ST_RUN, ST_STEP, ST_INJECT};
    busy           = dp_clk_en;
    inject_ready   = (state == ST_HALT);
    dp_debug       = (state == ST_INJECT);
    dp_debug_instr = dp_debug ? inj_instr_q : '0;
    dp_debug_memb  = dp_debug ? inj_memb_q  : '0;
  end

  bamf_cycle_counter #(.W(CYCLE_W)) u_cycle_counter (
    .clk   (clk),
    .rst   (reset),
    .clr   (cnt_clr),
    .en    (dp_clk_en),
    .count (cycle_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      result      <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      inj_instr_q <= '0;
      inj_memb_q  <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_RUN;
            done    <= 1'b0;
            timeout <= 1'b0;
          end
        end
        ST_RUN, ST_STEP, ST_INJECT: begin
          // Completion beats the limit, which beats halt; single-cycle states fall back to HALT.
          if (dp_outport_we) begin
            result <= dp_outport;
            done   <= 1'b1;
            state  <= ST_DONE;
          end else if (at_limit) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= ST_DONE;
          end else if ((state != ST_RUN) || halt_req) begin
            state <= ST_HALT;
          end
        end
        ST_HALT: begin
          if (inject_valid) begin
            inj_instr_q <= inject_instr;
            inj_memb_q  <= inject_memb;
            state       <= ST_INJECT;
          end else if (step) begin
            state <= ST_STEP;
          end else if (start) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bamf_run_controller.sv
// Directed bench for bamf_run_controller: vector table plus hand-written corner sequences.
module tb_bamf_run_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, halt_req, step, inject_valid, inject_ready;
  logic [15:0] inject_instr, inject_memb;
  logic        dp_outport_we;
  logic [15:0] dp_outport;
  logic        dp_clk_en, dp_debug;
  logic [15:0] dp_debug_instr, dp_debug_memb, result;
  logic        done, timeout, busy;
  logic [31:0] cycle_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  bamf_run_controller #(.CYCLE_W(32), .TIMEOUT(32'd10)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .halt_req       (halt_req),
    .step           (step),
    .inject_valid   (inject_valid),
    .inject_ready   (inject_ready),
    .inject_instr   (inject_instr),
    .inject_memb    (inject_memb),
    .dp_outport_we  (dp_outport_we),
    .dp_outport     (dp_outport),
    .dp_clk_en      (dp_clk_en),
    .dp_debug       (dp_debug),
    .dp_debug_instr (dp_debug_instr),
    .dp_debug_memb  (dp_debug_memb),
    .result         (result),
    .done           (done),
    .timeout        (timeout),
    .cycle_count    (cycle_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  in;    // {start, halt_req, step, inject_valid, dp_outport_we}
    logic [15:0] outp, instr, memb;
    logic [5:0]  ex;    // {dp_clk_en, busy, inject_ready, dp_debug, done, timeout}
    logic [15:0] ei, em, res;
    int unsigned cnt;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic [4:0] in, input logic [15:0] outp, instr, memb,
                              input logic [5:0] ex, input logic [15:0] ei, em, res,
                              input int unsigned cnt);
    vec_t v;
    v.in = in; v.outp = outp; v.instr = instr; v.memb = memb;
    v.ex = ex; v.ei = ei; v.em = em; v.res = res; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, got, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 0; halt_req = 0; step = 0; inject_valid = 0;
    dp_outport_we = 0; dp_outport = '0; inject_instr = '0; inject_memb = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string nm, input int idx, input logic en, input logic dn,
                           input logic to, input logic [15:0] res, input int unsigned cnt);
    chk({nm, ".en"},  idx, 32'(dp_clk_en),   32'(en));
    chk({nm, ".done"}, idx, 32'(done),       32'(dn));
    chk({nm, ".to"},  idx, 32'(timeout),     32'(to));
    chk({nm, ".res"}, idx, 32'(result),      32'(res));
    chk({nm, ".cnt"}, idx, cycle_count,      cnt);
  endtask

  initial begin
    vecs[0]  = mk(5'b10000, 16'h0, 16'h0, 16'h0, 6'b110000, 16'h0, 16'h0, 16'h0, 0);
    vecs[1]  = mk(5'b00000, 16'h0, 16'h0, 16'h0, 6'b110000, 16'h0, 16'h0, 16'h0, 1);
    vecs[2]  = mk(5'b00000, 16'h0, 16'h0, 16'h0, 6'b110000, 16'h0, 16'h0, 16'h0, 2);
    vecs[3]  = mk(5'b01000, 16'h0, 16'h0, 16'h0, 6'b001000, 16'h0, 16'h0, 16'h0, 3);
    vecs[4]  = mk(5'b00000, 16'h0, 16'h0, 16'h0, 6'b001000, 16'h0, 16'h0, 16'h0, 3);
    vecs[5]  = mk(5'b00001, 16'hFFFF, 16'h0, 16'h0, 6'b001000, 16'h0, 16'h0, 16'h0, 3);
    vecs[6]  = mk(5'b01000, 16'h0, 16'h0, 16'h0, 6'b001000, 16'h0, 16'h0, 16'h0, 3);
    vecs[7]  = mk(5'b00000, 16'h0, 16'h0, 16'h0, 6'b001000, 16'h0, 16'h0, 16'h0, 3);
    vecs[8]  = mk(5'b00000, 16'h0, 16'h0, 16'h0, 6'b001000, 16'h0, 16'h0, 16'h0, 3);
    vecs[9]  = mk(5'b00100, 16'h0, 16'h0, 16'h0, 6'b110000, 16'h0, 16'h0, 16'h0, 3);
    vecs[10] = mk(5'b00000, 16'h0, 16'h0, 16'h0, 6'b001000, 16'h0, 16'h0, 16'h0, 4);
    vecs[11] = mk(5'b00100, 16'h0, 16'h0, 16'h0, 6'b110000, 16'h0, 16'h0, 16'h0, 4);
    vecs[12] = mk(5'b00000, 16'h0, 16'h0, 16'h0, 6'b001000, 16'h0, 16'h0, 16'h0, 5);
    vecs[13] = mk(5'b10110, 16'h0, 16'hA5C3, 16'h0042, 6'b110100, 16'hA5C3, 16'h0042, 16'h0, 5);
    vecs[14] = mk(5'b00010, 16'h0, 16'h1111, 16'h2222, 6'b001000, 16'h0, 16'h0, 16'h0, 6);
    vecs[15] = mk(5'b10000, 16'h0, 16'h0, 16'h0, 6'b110000, 16'h0, 16'h0, 16'h0, 6);
    vecs[16] = mk(5'b00000, 16'h0, 16'h0, 16'h0, 6'b110000, 16'h0, 16'h0, 16'h0, 7);
    vecs[17] = mk(5'b00001, 16'h1234, 16'h0, 16'h0, 6'b000010, 16'h0, 16'h0, 16'h1234, 8);
    vecs[18] = mk(5'b00001, 16'hBEEF, 16'h0, 16'h0, 6'b000010, 16'h0, 16'h0, 16'h1234, 8);
    vecs[19] = mk(5'b10000, 16'h0, 16'h0, 16'h0, 6'b110000, 16'h0, 16'h0, 16'h1234, 0);
    vecs[20] = mk(5'b00000, 16'h0, 16'h0, 16'h0, 6'b110000, 16'h0, 16'h0, 16'h1234, 1);
    vecs[21] = mk(5'b01001, 16'h5678, 16'h0, 16'h0, 6'b000010, 16'h0, 16'h0, 16'h5678, 2);
    vecs[22] = mk(5'b10000, 16'h0, 16'h0, 16'h0, 6'b110000, 16'h0, 16'h0, 16'h5678, 0);
    vecs[23] = mk(5'b00000, 16'h0, 16'h0, 16'h0, 6'b110000, 16'h0, 16'h0, 16'h5678, 1);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk_state("rst", 0, 1'b0, 1'b0, 1'b0, 16'h0, 0);
    chk("rst.busy", 0, 32'(busy), 32'd0);
    chk("rst.rdy",  0, 32'(inject_ready), 32'd0);
    chk("rst.dbg",  0, 32'(dp_debug), 32'd0);
    chk("rst.di",   0, 32'(dp_debug_instr), 32'd0);

    // Halt/hold/step/inject/resume/done/restart scenario, one edge per vector.
    for (int i = 0; i < 24; i++) begin
      {start, halt_req, step, inject_valid, dp_outport_we} = vecs[i].in;
      dp_outport   = vecs[i].outp;
      inject_instr = vecs[i].instr;
      inject_memb  = vecs[i].memb;
      tick();
      chk("v.en",   i, 32'(dp_clk_en),     32'(vecs[i].ex[5]));
      chk("v.busy", i, 32'(busy),          32'(vecs[i].ex[4]));
      chk("v.rdy",  i, 32'(inject_ready),  32'(vecs[i].ex[3]));
      chk("v.dbg",  i, 32'(dp_debug),      32'(vecs[i].ex[2]));
      chk("v.done", i, 32'(done),          32'(vecs[i].ex[1]));
      chk("v.to",   i, 32'(timeout),       32'(vecs[i].ex[0]));
      chk("v.di",   i, 32'(dp_debug_instr), 32'(vecs[i].ei));
      chk("v.dm",   i, 32'(dp_debug_memb),  32'(vecs[i].em));
      chk("v.res",  i, 32'(result),        32'(vecs[i].res));
      chk("v.cnt",  i, cycle_count,        vecs[i].cnt);
    end
    idle_inputs();

    // Reset mid-run: outputs must drop before any clock edge.
    tick();
    tick();
    chk("mid.precnt", 0, cycle_count, 32'd3);
    #3 reset = 1'b1;
    #1;
    chk("mid.en",   0, 32'(dp_clk_en), 32'd0);
    chk("mid.busy", 0, 32'(busy),      32'd0);
    chk("mid.cnt",  0, cycle_count,    32'd0);
    chk("mid.res",  0, 32'(result),    32'd0);
    #1 reset = 1'b0;

    // Basic run: completion on the 7th enabled cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_state("basic0", 0, 1'b1, 1'b0, 1'b0, 16'h0, 0);
    repeat (6) tick();
    chk_state("basic6", 0, 1'b1, 1'b0, 1'b0, 16'h0, 6);
    dp_outport_we = 1'b1; dp_outport = 16'h0017;
    tick();
    idle_inputs();
    chk_state("basic7", 0, 1'b0, 1'b1, 1'b0, 16'h0017, 7);

    // Timeout with no completion: exactly 10 enabled cycles; result held from the last run.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_state("to0", 0, 1'b1, 1'b0, 1'b0, 16'h0017, 0);
    repeat (9) tick();
    chk_state("to9", 0, 1'b1, 1'b0, 1'b0, 16'h0017, 9);
    tick();
    chk_state("to10", 0, 1'b0, 1'b1, 1'b1, 16'h0017, 10);
    tick();
    chk_state("to11", 0, 1'b0, 1'b1, 1'b1, 16'h0017, 10);

    // Completion on the limit cycle: done without timeout.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_state("tw0", 0, 1'b1, 1'b0, 1'b0, 16'h0017, 0);
    repeat (9) tick();
    dp_outport_we = 1'b1; dp_outport = 16'h00AA;
    tick();
    idle_inputs();
    chk_state("tw10", 0, 1'b0, 1'b1, 1'b0, 16'h00AA, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
